wb_deserializer: RTL and testbench

- Receive-side counterpart of the Wishbone serializer link.
- Samples a single-bit serial line one bit per clk_i cycle and detects framed 27-bit words: three 9-bit fields {k, byte}, where k=1 marks a kcode and k=0 marks data.
- Buffers received words in a small FIFO.
- Exposes data, status and control registers to a Wishbone master on the same clock.

---
 rtl/wb_deserializer_pkg.sv | 25 ++
 rtl/deserializer_out.sv | 65 ++++++
 rtl/wb_deserializer.sv | 149 ++++++++++++++
 tb/tb_wb_deserializer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_deserializer_pkg.sv
// Shared constants and types for the Wishbone serial receiver: register map,
// frame geometry, status bit positions and the receive FSM state type.
package wb_deserializer_pkg;

   localparam int         NUM_REGS   = 4;
   localparam logic [1:0] ADR_DATA   = 2'd0;
   localparam logic [1:0] ADR_STATUS = 2'd1;
   localparam logic [1:0] ADR_CTRL   = 2'd2;

   localparam int         FRAME_BITS = 27;
   localparam logic [8:0] KCODE_LEAD = 9'h1BC;

   localparam int ST_NOT_EMPTY = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVERRUN   = 2;
   localparam int ST_FRAME_ERR = 3;
   localparam int ST_LEVEL_LSB = 8;
   localparam int ST_DISC_LSB  = 16;

   localparam int CTRL_CLEAR = 0;
   localparam int CTRL_FLUSH = 1;

   typedef enum logic [1:0] {IDLE, SHIFT, STOP} rx_state_t;

endpackage

// File: rtl/deserializer_out.sv
// Serial frame receiver: hunts for a start bit, shifts in FRAME_BITS payload
// bits MSB first and reports the word (or a framing error) on the stop bit.
module deserializer_out #(
   parameter int FRAME_BITS = wb_deserializer_pkg::FRAME_BITS
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  data_i,
   output logic [FRAME_BITS-1:0] word_o,
   output logic                  word_valid_o,
   output logic                  frame_err_o
);
   import wb_deserializer_pkg::*;

   localparam int              CNT_W    = $clog2(FRAME_BITS);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

   rx_state_t             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
      end
   end

   // Pulses are combinational on the stop-bit cycle so the FIFO captures the
   // word on the same edge that samples the stop bit.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shreg_d      = shreg_q;
      word_valid_o = 1'b0;
      frame_err_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (data_i) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], data_i};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) state_d = STOP;
         end
         STOP: begin
            state_d = IDLE;
            if (data_i) frame_err_o  = 1'b1;
            else        word_valid_o = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign word_o = shreg_q;

endmodule

// File: rtl/wb_deserializer.sv
// Wishbone-facing serial link receiver: word FIFO, sticky status flags and
// register decode. Define KCODE_FILTER_EN to keep only K28.5-led words.
module wb_deserializer #(
   parameter int DEPTH      = 4,
   parameter int FRAME_BITS = wb_deserializer_pkg::FRAME_BITS
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        data_i,
   input  logic        CYC_I,
   input  logic        STB_I,
   input  logic        WE_I,
   input  logic [31:0] ADR_I,
   input  logic [31:0] DAT_I,
   output logic        ACK_O,
   output logic        ERR_O,
   output logic [31:0] DAT_O,
   output logic        irq_o
);
   import wb_deserializer_pkg::*;

   localparam int AW    = $clog2(DEPTH);
   localparam int ADR_W = $clog2(NUM_REGS);

   logic [FRAME_BITS-1:0] rx_word;
   logic                  rx_valid, rx_ferr;

   deserializer_out #(.FRAME_BITS(FRAME_BITS)) u_rx (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .data_i      (data_i),
      .word_o      (rx_word),
      .word_valid_o(rx_valid),
      .frame_err_o (rx_ferr)
   );

   logic [FRAME_BITS-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]           cnt_q;
   logic                  overrun_q, ferr_q;
   logic [7:0]            discards;
   logic                  lead_ok;

   logic             req, rd, wr, mapped, ctrl_wr, flush, clr;
   logic             not_empty, full, accept, push, pop, ovr_set;
   logic [ADR_W-1:0] adr;
   logic [31:0]      status;
   logic             unused_bits;

   assign unused_bits = ^{ADR_I[31:ADR_W], DAT_I[31:2]};

   assign adr     = ADR_I[ADR_W-1:0];
   assign req     = CYC_I & STB_I;
   assign mapped  = (adr <= ADR_CTRL);
   assign ACK_O   = req & mapped;
   assign ERR_O   = req & ~mapped;
   assign rd      = req & ~WE_I;
   assign wr      = req & WE_I;
   assign ctrl_wr = wr & (adr == ADR_CTRL);
   assign flush   = ctrl_wr & DAT_I[CTRL_FLUSH];
   assign clr     = ctrl_wr & DAT_I[CTRL_CLEAR];

   assign not_empty = (cnt_q != '0);
   assign full      = (cnt_q == (AW+1)'(DEPTH));
   assign pop       = rd & (adr == ADR_DATA) & not_empty;

   // A flush drops any word arriving in the same cycle without flagging overrun.
   assign accept  = rx_valid & lead_ok & ~flush;
   assign push    = accept & (~full | pop);
   assign ovr_set = accept & full & ~pop;

`ifdef KCODE_FILTER_EN
   assign lead_ok = (rx_word[FRAME_BITS-1 -: 9] == KCODE_LEAD);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         discards <= '0;
      end else if (rx_valid && !lead_ok && discards != 8'hFF) begin
         discards <= clr ? 8'd1 : discards + 8'd1;
      end else if (clr) begin
         discards <= '0;
      end
   end
`else
   assign lead_ok  = 1'b1;
   assign discards = '0;
`endif

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= rx_word;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Sticky flags: a set event in the same cycle as a clear keeps the flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         if (ovr_set)  overrun_q <= 1'b1;
         else if (clr) overrun_q <= 1'b0;
         if (rx_ferr)  ferr_q    <= 1'b1;
         else if (clr) ferr_q    <= 1'b0;
      end
   end

   always_comb begin
      status                          = '0;
      status[ST_NOT_EMPTY]            = not_empty;
      status[ST_FULL]                 = full;
      status[ST_OVERRUN]              = overrun_q;
      status[ST_FRAME_ERR]            = ferr_q;
      status[ST_LEVEL_LSB +: 8]       = 8'(cnt_q);
      status[ST_DISC_LSB +: 8]        = discards;
   end

   always_comb begin
      DAT_O = '0;
      if (rd) begin
         case (adr)
            ADR_DATA:   if (not_empty) DAT_O = 32'(mem_q[rd_ptr_q]);
            ADR_STATUS: DAT_O = status;
            default:    DAT_O = '0;
         endcase
      end
   end

   assign irq_o = not_empty | overrun_q | ferr_q;

endmodule

// File: tb/tb_wb_deserializer.sv
// Directed bench for wb_deserializer: table of bus-decode vectors plus
// hand-written frame sequences for FIFO, flag and reset corner cases.
`timescale 1ns/1ps
module tb_wb_deserializer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        data_i = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0] adr = '0, wdat = '0;
   logic [31:0] rdat;
   logic        ack, err, irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_deserializer #(.DEPTH(DEPTH), .FRAME_BITS(27)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .data_i(data_i),
      .CYC_I (cyc),
      .STB_I (stb),
      .WE_I  (we),
      .ADR_I (adr),
      .DAT_I (wdat),
      .ACK_O (ack),
      .ERR_O (err),
      .DAT_O (rdat),
      .irq_o (irq)
   );

   typedef struct {
      logic        cyc, stb, we;
      logic [1:0]  adr;
      logic [31:0] wd;
      logic [31:0] exp_dat;
      logic        exp_ack, exp_err;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                      output logic [31:0] q, output logic k, output logic e);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = {30'b0, a}; wdat = d;
      #1;
      q = rdat; k = ack; e = err;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0;
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] q;
      logic        k, e;
      bus(1'b0, a, 32'h0, q, k, e);
      chk(name, q, exp);
   endtask

   task automatic wr_ctrl(input logic [31:0] d);
      logic [31:0] q;
      logic        k, e;
      bus(1'b1, 2'd2, d, q, k, e);
   endtask

   task automatic send_body(input logic [26:0] w);
      @(negedge clk) data_i = 1'b1;
      for (int i = 26; i >= 0; i--) begin
         @(negedge clk) data_i = w[i];
      end
   endtask

   task automatic send_frame(input logic [26:0] w, input logic stop);
      send_body(w);
      @(negedge clk) data_i = stop;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk) data_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] q;
      logic        k, e;

      vecs[0] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h0,        32'h0, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 2'd1, 32'h0,        32'h0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h0,        32'h0, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 2'd3, 32'h0,        32'h0, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 2'd0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 2'd1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 2'd3, 32'h0,        32'h0, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 2'd1, 32'h0,        32'h0, 1'b0, 1'b0};
      vecs[8] = '{1'b0, 1'b1, 1'b0, 2'd3, 32'h0,        32'h0, 1'b0, 1'b0};
      vecs[9] = '{1'b1, 1'b1, 1'b1, 2'd2, 32'h0,        32'h0, 1'b1, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      rd_chk("reset_status", 2'd1, 32'h0);
      chk("reset_irq", {31'b0, irq}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      bus(1'b0, 2'd1, 32'h0, q, k, e);
      chk("post_reset_status", q, 32'h0);
      chk("post_reset_ack", {31'b0, k}, 32'h1);

      // Single K28.5-led frame
      send_frame(27'h6F02434, 1'b0);
      idle(1);
      rd_chk("t1_status", 2'd1, 32'h0000_0101);
      chk("t1_irq", {31'b0, irq}, 32'h1);
      rd_chk("t1_data", 2'd0, 32'h06F0_2434);
      rd_chk("t1_status_after", 2'd1, 32'h0);

      // Overrun with DEPTH+1 back-to-back frames
      for (int n = 1; n <= DEPTH + 1; n++) send_frame(27'(n), 1'b0);
      idle(1);
      rd_chk("t2_status", 2'd1, 32'h0000_0407);
      for (int n = 1; n <= DEPTH; n++) rd_chk($sformatf("t2_data%0d", n), 2'd0, 32'(n));
      rd_chk("t2_data_empty", 2'd0, 32'h0);
      rd_chk("t2_status_sticky", 2'd1, 32'h0000_0004);
      chk("t2_irq_sticky", {31'b0, irq}, 32'h1);
      wr_ctrl(32'h1);
      rd_chk("t2_status_clr", 2'd1, 32'h0);

      // Framing error
      send_frame(27'h1234567, 1'b1);
      idle(1);
      rd_chk("t3_status", 2'd1, 32'h0000_0008);
      chk("t3_irq", {31'b0, irq}, 32'h1);
      wr_ctrl(32'h1);
      rd_chk("t3_status_clr", 2'd1, 32'h0);
      chk("t3_irq_clr", {31'b0, irq}, 32'h0);

      // Bus decode table with FIFO empty and flags clear
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         cyc = vecs[i].cyc; stb = vecs[i].stb; we = vecs[i].we;
         adr = {30'b0, vecs[i].adr}; wdat = vecs[i].wd;
         #1;
         chk($sformatf("vec%0d_dat", i), rdat, vecs[i].exp_dat);
         chk($sformatf("vec%0d_ack", i), {31'b0, ack}, {31'b0, vecs[i].exp_ack});
         chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
         @(negedge clk);
         cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0;
      end
      rd_chk("vec_status_after", 2'd1, 32'h0);

      // Pop coincident with push while full
      for (int n = 0; n < DEPTH; n++) send_frame(27'h11 + 27'(n), 1'b0);
      idle(1);
      rd_chk("t4_status_full", 2'd1, 32'h0000_0403);
      send_body(27'h15);
      @(negedge clk);
      data_i = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd0;
      #1;
      chk("t4_pop_data", rdat, 32'h11);
      chk("t4_pop_ack", {31'b0, ack}, 32'h1);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      rd_chk("t4_status", 2'd1, 32'h0000_0403);
      for (int n = 0; n < DEPTH; n++) rd_chk($sformatf("t4_data%0d", n), 2'd0, 32'h12 + 32'(n));
      rd_chk("t4_status_empty", 2'd1, 32'h0);

      // Flush coincident with push
      send_frame(27'h21, 1'b0);
      idle(1);
      rd_chk("flush_pre", 2'd1, 32'h0000_0101);
      send_body(27'h22);
      @(negedge clk);
      data_i = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd2; wdat = 32'h2;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0;
      rd_chk("flush_status", 2'd1, 32'h0);

      // Flag clear coincident with framing error
      send_body(27'h33);
      @(negedge clk);
      data_i = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd2; wdat = 32'h1;
      @(negedge clk);
      data_i = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0;
      rd_chk("setwins_status", 2'd1, 32'h0000_0008);
      wr_ctrl(32'h1);

      // Unmapped address, then reset mid-frame
      bus(1'b0, 2'd3, 32'h0, q, k, e);
      chk("t5_err", {31'b0, e}, 32'h1);
      chk("t5_ack", {31'b0, k}, 32'h0);
      send_frame(27'h44, 1'b0);
      idle(1);
      rd_chk("t5_pre_reset", 2'd1, 32'h0000_0101);
      @(negedge clk) data_i = 1'b1;
      for (int i = 26; i > 16; i--) begin
         @(negedge clk) data_i = 27'h5A5A5A5 >> i;
      end
      @(negedge clk);
      rst_n = 1'b0; data_i = 1'b0;
      #1;
      chk("t5_reset_irq", {31'b0, irq}, 32'h0);
      idle(2);
      rst_n = 1'b1;
      rd_chk("t5_post_reset", 2'd1, 32'h0);
      send_frame(27'h5A5A5A5, 1'b0);
      idle(1);
      rd_chk("t5_data", 2'd0, 32'h05A5_A5A5);
      rd_chk("t5_status_after", 2'd1, 32'h0);

      // K-code lead filtering
      send_frame(27'h0002434, 1'b0);
      send_frame(27'h6F02434, 1'b0);
      idle(1);
`ifdef KCODE_FILTER_EN
      rd_chk("t6_status", 2'd1, 32'h0001_0101);
      rd_chk("t6_data", 2'd0, 32'h06F0_2434);
      rd_chk("t6_status_after", 2'd1, 32'h0001_0000);
      wr_ctrl(32'h1);
      rd_chk("t6_status_clr", 2'd1, 32'h0);
`else
      rd_chk("t6_status", 2'd1, 32'h0000_0201);
      rd_chk("t6_data0", 2'd0, 32'h0000_2434);
      rd_chk("t6_data1", 2'd0, 32'h06F0_2434);
      rd_chk("t6_status_after", 2'd1, 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
